des3_sched: RTL and testbench
=============================

# des3_sched

Round-robin scheduler that shares one fully pipelined `des3_perf` core among `NUM_REQ` requesters. It accepts at most one job per cycle, drives the core's data/key/decrypt inputs, and tags each job with its requester ID through a shift register matched to the core latency. Each result returns to the originating requester. It sits between the top-level stimulus logic and the `des3_perf` instance; the core itself is unchanged.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `LATENCY`, 48: clock edges from core input presented to matching `desOut` valid.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `hold`  in  1  when 1, no new grants; in-flight jobs drain normally.
- `req_valid`  in  NUM_REQ  per-requester job pending.
- `req_ready`  out  NUM_REQ  one-hot grant, combinational from `req_valid`, `hold` and the pointer.
- `req_data`  in  64*NUM_REQ  plaintext/ciphertext; slice i = bits [64i+63:64i].
- `req_key1`, `req_key2`, `req_key3`  in  56*NUM_REQ  keys, same slicing at 56 bits.
- `req_decrypt`  in  NUM_REQ  1 = decrypt.
- `core_desIn`  out  64  to core.
- `core_key1`, `core_key2`, `core_key3`  out  56  to core.
- `core_decrypt`  out  1  to core.
- `core_desOut`  in  64  from core.
- `rsp_valid`  out  NUM_REQ  one-hot, one-cycle pulse per result.
- `rsp_data`  out  64  result, valid while any `rsp_valid` bit is set.
- `inflight`  out  $clog2(LATENCY+2)  jobs accepted but not yet returned.
- `idle`  out  1  `inflight==0` and no `req_valid` bit set.

## Operation
- Accept: requester i is accepted on an edge where `req_valid[i] & req_ready[i]`. At most one `req_ready` bit is 1. All `req_ready` bits are 0 when `hold=1` or during reset.
- Round robin: `ptr` (reset 0) is the highest-priority index. The first valid requester scanning ptr, ptr+1, … (mod NUM_REQ) is granted. On accept of i, `ptr` becomes (i+1) mod NUM_REQ; otherwise it is unchanged.
- Issue: on accept, `core_*` register slice i of the request. With no accept, `core_*` hold their last values, and the core output for that slot is ignored.
- Tag pipe: LATENCY+1 stages of {vld, id}.
  - Stage 0 is loaded with {accept, granted id} every edge. Each stage shifts every edge.
  - The pipe never stalls; throughput is 1 job/cycle.
- Return: on the edge where tag stage LATENCY has vld=1, `rsp_data` captures `core_desOut` and `rsp_valid[id]` is asserted for exactly one cycle. Requesters must always accept a response; there is no output backpressure.
- `inflight`: increments on accept and decrements on response. Both on the same edge leaves it unchanged. It never exceeds LATENCY+1.
- `hold` has no effect on jobs already in the tag pipe.

## Timing
- Reset values: `core_*`=0, `rsp_valid`=0, `rsp_data`=0, `inflight`=0, `ptr`=0, all tag vld=0. `idle`=1 when no `req_valid` bit is set.
- Latency: a job accepted at edge E0 gives `rsp_valid` high in the cycle after edge E0+LATENCY+1.
- Reset mid-operation: all tags are cleared. In-flight results are discarded, and no `rsp_valid` is asserted for them. The core's pipeline contents are ignored.
- Simultaneous requests: with all `req_valid` high, grants are strictly i, i+1, … with no gap cycles.
- `req_valid` dropping without a grant is legal. No job is recorded.

## Configuration
- `DES3_SCHED_FIXED_PRIO_EN`:
  - Defined: fixed priority; the lowest valid index always wins and `ptr` is removed.
  - Undefined (default): round robin as above.

## Test plan
- Single job: requester 2 submits data 0x0123456789ABCDEF with all keys 0x0 and encrypt, at edge 10. Required: `rsp_valid`=4'b0100 in the cycle after edge 10+LATENCY+1. `rsp_data` equals the behavioural 3DES model output. `inflight` returns to 0.
- Round trip: encrypt a value, then resubmit the result with `decrypt=1` and the same keys. Required: `rsp_data` equals the original 64-bit value.
- Contention: all four `req_valid` held high for 8 cycles from reset. Required grant order is 0,1,2,3,0,1,2,3. Responses arrive in the same order with matching IDs, on consecutive cycles.
- Reset mid-flight: issue 5 jobs, then assert `reset` at edge E0+20. Required: no `rsp_valid` pulse for the next 2*LATENCY cycles, `inflight`=0, `idle`=1.
- `hold`: assert with 3 jobs in flight and requester 1 valid. Required:
  - `req_ready`=0 while held;
  - all 3 responses still delivered;
  - requester 1 granted on the first cycle after `hold` deasserts.
- With `DES3_SCHED_FIXED_PRIO_EN` defined: requesters 0 and 3 both valid continuously. Required: only requester 0 is granted.

Source files
------------

// File: rtl/des3_sched.sv
// Round-robin front end sharing one pipelined des3_perf core among NUM_REQ requesters.
// Define DES3_SCHED_FIXED_PRIO_EN for fixed lowest-index-wins arbitration (no pointer).
module des3_sched #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 48
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           hold,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [64*NUM_REQ-1:0]          req_data,
    input  logic [56*NUM_REQ-1:0]          req_key1,
    input  logic [56*NUM_REQ-1:0]          req_key2,
    input  logic [56*NUM_REQ-1:0]          req_key3,
    input  logic [NUM_REQ-1:0]             req_decrypt,
    output logic [63:0]                    core_desIn,
    output logic [55:0]                    core_key1,
    output logic [55:0]                    core_key2,
    output logic [55:0]                    core_key3,
    output logic                           core_decrypt,
    input  logic [63:0]                    core_desOut,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [63:0]                    rsp_data,
    output logic [$clog2(LATENCY+2)-1:0]   inflight,
    output logic                           idle
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(LATENCY+2);

    logic [ID_W-1:0]    gnt_id;
    logic               accept;
    logic [ID_W-1:0]    scan_idx;

    logic [63:0]        desin_q;
    logic [55:0]        key1_q, key2_q, key3_q;
    logic               dec_q;

    logic [LATENCY:0]   tag_vld_q;
    logic [ID_W-1:0]    tag_id_q [LATENCY+1];
    logic               ret;

    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [63:0]        rsp_data_q;
    logic [CNT_W-1:0]   inflight_q, inflight_d;

`ifndef DES3_SCHED_FIXED_PRIO_EN
    logic [ID_W-1:0]    ptr_q, ptr_d;
`endif

    always_comb begin
        req_ready = '0;
        gnt_id    = '0;
        accept    = 1'b0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef DES3_SCHED_FIXED_PRIO_EN
            scan_idx = ID_W'(k);
`else
            scan_idx = ID_W'((32'(ptr_q) + k) % NUM_REQ);
`endif
            if (!accept && req_valid[scan_idx]) begin
                accept              = 1'b1;
                gnt_id              = scan_idx;
                req_ready[scan_idx] = 1'b1;
            end
        end
        if (hold || reset) begin
            req_ready = '0;
            accept    = 1'b0;
        end
    end

`ifndef DES3_SCHED_FIXED_PRIO_EN
    always_comb begin
        ptr_d = ptr_q;
        if (accept)
            ptr_d = (32'(gnt_id) == NUM_REQ-1) ? '0 : gnt_id + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
`endif

    // Core inputs only move on accept; idle slots replay the last job and are ignored via the tag pipe.
    always_ff @(posedge clk) begin
        if (reset) begin
            desin_q <= '0;
            key1_q  <= '0;
            key2_q  <= '0;
            key3_q  <= '0;
            dec_q   <= 1'b0;
        end else if (accept) begin
            desin_q <= req_data[64*gnt_id +: 64];
            key1_q  <= req_key1[56*gnt_id +: 56];
            key2_q  <= req_key2[56*gnt_id +: 56];
            key3_q  <= req_key3[56*gnt_id +: 56];
            dec_q   <= req_decrypt[gnt_id];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) tag_vld_q <= '0;
        else       tag_vld_q <= {tag_vld_q[LATENCY-1:0], accept};
    end

    always_ff @(posedge clk) begin
        tag_id_q[0] <= gnt_id;
        for (int unsigned i = 1; i <= LATENCY; i++)
            tag_id_q[i] <= tag_id_q[i-1];
    end

    assign ret = tag_vld_q[LATENCY];

    always_comb begin
        rsp_valid_d = '0;
        if (ret) rsp_valid_d = NUM_REQ'(1) << tag_id_q[LATENCY];
        inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(ret);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            inflight_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            if (ret) rsp_data_q <= core_desOut;
            inflight_q  <= inflight_d;
        end
    end

    assign core_desIn   = desin_q;
    assign core_key1    = key1_q;
    assign core_key2    = key2_q;
    assign core_key3    = key3_q;
    assign core_decrypt = dec_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign inflight     = inflight_q;
    assign idle         = (inflight_q == '0) && (req_valid == '0);

endmodule

// File: tb/tb_des3_sched.sv
// Scoreboard bench for des3_sched with a stand-in LATENCY-deep invertible cipher core.
// The scheduler is data-agnostic, so the core is modelled by a keyed reversible transform.
module tb_des3_sched;

    localparam int NR  = 4;
    localparam int LAT = 48;
    localparam int CW  = $clog2(LAT+2);

    logic              clk, reset, hold;
    logic [NR-1:0]     req_valid, req_ready, req_decrypt, rsp_valid;
    logic [64*NR-1:0]  req_data;
    logic [56*NR-1:0]  req_key1, req_key2, req_key3;
    logic [63:0]       core_desIn, core_desOut, rsp_data;
    logic [55:0]       core_key1, core_key2, core_key3;
    logic              core_decrypt;
    logic [CW-1:0]     inflight;
    logic              idle;

    des3_sched #(.NUM_REQ(NR), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .hold(hold),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .req_key1(req_key1), .req_key2(req_key2), .req_key3(req_key3),
        .req_decrypt(req_decrypt),
        .core_desIn(core_desIn), .core_key1(core_key1), .core_key2(core_key2),
        .core_key3(core_key3), .core_decrypt(core_decrypt), .core_desOut(core_desOut),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .inflight(inflight), .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] rotl(logic [63:0] x, int n);
        return (x << n) | (x >> (64 - n));
    endfunction

    function automatic logic [63:0] rotr(logic [63:0] x, int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [63:0] cipher(logic [63:0] d, logic [55:0] k1, logic [55:0] k2,
                                           logic [55:0] k3, logic dec);
        logic [63:0] x;
        if (!dec) begin
            x = rotl(d ^ {k1, 8'hA5}, 13);
            x = x + {k2, 8'h3C};
            x = rotl(x ^ {k3, 8'h96}, 29);
        end else begin
            x = rotr(d, 29) ^ {k3, 8'h96};
            x = x - {k2, 8'h3C};
            x = rotr(x, 13) ^ {k1, 8'hA5};
        end
        return x;
    endfunction

    // Stand-in core: LATENCY register stages, input sampled one edge after issue.
    logic [63:0] cpipe [LAT];
    always @(posedge clk) begin
        cpipe[0] <= cipher(core_desIn, core_key1, core_key2, core_key3, core_decrypt);
        for (int i = 1; i < LAT; i++) cpipe[i] <= cpipe[i-1];
    end
    assign core_desOut = cpipe[LAT-1];

    int total = 0;
    int bad   = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at t=%0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        int          acc;
        int          due;
        int          id;
        logic [63:0] data;
    } exp_t;

    exp_t sbq[$];
    int   cyc  = 0;
    int   mptr = 0;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            sbq.delete();
            mptr = 0;
        end
    end

    // Reference arbiter: decides the expected grant and pushes the expected response.
    always @(negedge clk) begin
        logic [NR-1:0] eg;
        int gi;
        int j;
        exp_t e;
        eg = '0;
        gi = -1;
        if (!reset && !hold) begin
            for (int k = 0; k < NR; k++) begin
`ifdef DES3_SCHED_FIXED_PRIO_EN
                j = k;
`else
                j = (mptr + k) % NR;
`endif
                if (gi < 0 && req_valid[j]) gi = j;
            end
        end
        if (gi >= 0) eg[gi] = 1'b1;
        chk("grant", 64'(req_ready), 64'(eg));
        if (gi >= 0) begin
            e.acc  = cyc + 1;
            e.due  = cyc + LAT + 2;
            e.id   = gi;
            e.data = cipher(req_data[64*gi +: 64], req_key1[56*gi +: 56],
                            req_key2[56*gi +: 56], req_key3[56*gi +: 56], req_decrypt[gi]);
            sbq.push_back(e);
            mptr = (gi + 1) % NR;
        end
    end

    // Monitor: pops on every response, flags missing/unexpected ones, tracks inflight/idle.
    always @(negedge clk) begin
        exp_t e;
        int n;
        logic [NR-1:0] oh;
        if (rsp_valid != '0) begin
            if (sbq.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                e  = sbq.pop_front();
                oh = '0;
                oh[e.id] = 1'b1;
                chk("rsp_cycle", 64'(cyc), 64'(e.due));
                chk("rsp_id", 64'(rsp_valid), 64'(oh));
                chk("rsp_data", rsp_data, e.data);
            end
        end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e  = sbq.pop_front();
            oh = '0;
            oh[e.id] = 1'b1;
            chk("rsp_missing", 64'(rsp_valid), 64'(oh));
        end
        n = 0;
        foreach (sbq[q]) if (sbq[q].acc <= cyc && sbq[q].due > cyc) n++;
        chk("inflight", 64'(inflight), 64'(n));
        chk("idle", 64'(idle), 64'((n == 0) && (req_valid == '0)));
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_req(int i, logic [63:0] d, logic [55:0] k1, logic [55:0] k2,
                           logic [55:0] k3, logic dec);
        req_data[64*i +: 64] = d;
        req_key1[56*i +: 56] = k1;
        req_key2[56*i +: 56] = k2;
        req_key3[56*i +: 56] = k3;
        req_decrypt[i]       = dec;
    endtask

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    task automatic rand_all();
        for (int i = 0; i < NR; i++)
            set_req(i, r64(), r64()[55:0], r64()[55:0], r64()[55:0], 1'($urandom));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 4*LAT && sbq.size() > 0; i++) tick(1);
        if (sbq.size() > 0) chk("drain_timeout", 64'(sbq.size()), 64'd0);
        tick(2);
    endtask

    task automatic wait_rsp(int id, output logic [63:0] d, output logic got);
        got = 1'b0;
        d   = '0;
        for (int i = 0; i < 3*LAT && !got; i++) begin
            @(negedge clk);
            if (rsp_valid[id]) begin
                got = 1'b1;
                d   = rsp_data;
            end
        end
        chk("rsp_wait", 64'(got), 64'd1);
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] orig, ct, pt;
        logic [55:0] k1, k2, k3;
        logic        got;

        reset = 1'b1; hold = 1'b0; req_valid = '0;
        req_data = '0; req_key1 = '0; req_key2 = '0; req_key3 = '0; req_decrypt = '0;
        tick(3);
        reset = 1'b0;

        // Single job from requester 2, accepted at edge 10.
        tick(6);
        set_req(2, 64'h0123456789ABCDEF, '0, '0, '0, 1'b0);
        req_valid = 4'b0100;
        tick(1);
        req_valid = '0;
        wait_drain();
        chk("single_inflight", 64'(inflight), 64'd0);
        chk("single_idle", 64'(idle), 64'd1);

        // Round trip: encrypt on requester 1, decrypt the result on requester 3.
        orig = r64(); k1 = r64()[55:0]; k2 = r64()[55:0]; k3 = r64()[55:0];
        set_req(1, orig, k1, k2, k3, 1'b0);
        req_valid = 4'b0010;
        tick(1);
        req_valid = '0;
        wait_rsp(1, ct, got);
        set_req(3, ct, k1, k2, k3, 1'b1);
        req_valid = 4'b1000;
        tick(1);
        req_valid = '0;
        wait_rsp(3, pt, got);
        chk("roundtrip", pt, orig);
        wait_drain();

        // Contention from reset: all requesters valid for 8 cycles.
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            rand_all();
            #1;
`ifdef DES3_SCHED_FIXED_PRIO_EN
            chk("contention_order", 64'(req_ready), 64'd1);
`else
            chk("contention_order", 64'(req_ready), 64'(1) << (k % NR));
`endif
            tick(1);
        end
        req_valid = '0;
        wait_drain();

        // Reset mid-flight: 5 jobs, reset at E0+20, nothing may come back.
        for (int k = 0; k < 5; k++) begin
            rand_all();
            req_valid = '0;
            req_valid[k % NR] = 1'b1;
            tick(1);
        end
        req_valid = '0;
        tick(15);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(2*LAT);
        chk("rst_inflight", 64'(inflight), 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);

        // Hold with 3 jobs in flight and requester 1 waiting.
        for (int k = 0; k < 3; k++) begin
            rand_all();
            req_valid = '0;
            req_valid[(k == 0) ? 0 : k + 1] = 1'b1;
            tick(1);
        end
        hold = 1'b1;
        req_valid = 4'b0010;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("hold_ready", 64'(req_ready), 64'd0);
            tick(1);
        end
        hold = 1'b0;
        #1;
        chk("hold_release", 64'(req_ready), 64'b0010);
        tick(1);
        req_valid = '0;
        wait_drain();

`ifdef DES3_SCHED_FIXED_PRIO_EN
        req_valid = 4'b1001;
        for (int k = 0; k < 10; k++) begin
            rand_all();
            #1;
            chk("fixed_prio", 64'(req_ready), 64'b0001);
            tick(1);
        end
        req_valid = '0;
        wait_drain();
`endif

        // Randomized traffic with occasional hold.
        for (int k = 0; k < 400; k++) begin
            rand_all();
            req_valid = NR'($urandom);
            hold      = ($urandom_range(0, 7) == 0);
            tick(1);
        end
        req_valid = '0;
        hold      = 1'b0;
        wait_drain();
        chk("final_inflight", 64'(inflight), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
